// File: rtl/ip_2port_ram_pkg.sv
// Shared definitions for the ip_2port_ram self-test: controller state
// encoding and the default RAM geometry.
package ip_2port_ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port on the
// same clock. The array itself is never reset; only the read register is.
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data holds its last value whenever no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ip_2port_ram.sv
// RAM self-test: fills an sdp_ram with an address+pass pattern, reads it
// back, and latches a sticky error flag on any mismatch. Repeats forever.
module ip_2port_ram
  import ip_2port_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state;

  (* keep *) logic              ram_wr_en;
  (* keep *) logic [ADDR_W-1:0] ram_wr_addr;
  (* keep *) logic [DATA_W-1:0] ram_wr_data;
  (* keep *) logic              ram_rd_en;
  (* keep *) logic [ADDR_W-1:0] ram_rd_addr;
  (* keep *) logic [DATA_W-1:0] ram_rd_data;
  (* keep *) logic [DATA_W-1:0] pass_cnt;
  (* keep *) logic              rd_err;

  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [DATA_W-1:0] pass_cnt_nxt;

  assign wr_addr_nxt  = ram_wr_addr + 1'b1;
  assign pass_cnt_nxt = pass_cnt + 1'b1;

  sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .we    (ram_wr_en),
    .waddr (ram_wr_addr),
    .wdata (ram_wr_data),
    .re    (ram_rd_en),
    .raddr (ram_rd_addr),
    .rdata (ram_rd_data)
  );

  // Enables, addresses and write data are registered alongside the state so
  // the RAM sees them in the same cycle the state becomes WRITE or READ.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      pass_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state       <= WRITE;
          ram_wr_en   <= 1'b1;
          ram_wr_addr <= '0;
          ram_wr_data <= pass_cnt;
        end
        WRITE: begin
          if (ram_wr_addr == LAST_ADDR) begin
            state       <= READ;
            ram_wr_en   <= 1'b0;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= '0;
          end else begin
            ram_wr_addr <= wr_addr_nxt;
            ram_wr_data <= DATA_W'(wr_addr_nxt) + pass_cnt;
          end
        end
        READ: begin
          if (ram_rd_addr == LAST_ADDR) begin
            state       <= WRITE;
            ram_rd_en   <= 1'b0;
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= '0;
            ram_wr_data <= pass_cnt_nxt;
            pass_cnt    <= pass_cnt_nxt;
          end else begin
            ram_rd_addr <= ram_rd_addr + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ram_wr_en <= 1'b0;
          ram_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // The expected word travels one stage behind the read request, so the
  // final compare of a pass still uses the old pass count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmp_vld <= 1'b0;
      cmp_exp <= '0;
      rd_err  <= 1'b0;
    end else begin
      cmp_vld <= ram_rd_en;
      if (ram_rd_en) begin
        cmp_exp <= DATA_W'(ram_rd_addr) + pass_cnt;
      end
      rd_err <= rd_err | (cmp_vld && (ram_rd_data != cmp_exp));
    end
  end

  a_port_excl: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    !(ram_wr_en && ram_rd_en));

endmodule

// File: tb/tb_ip_2port_ram.sv
// Self-checking bench for ip_2port_ram: probes internal signals and checks
// them against a cycle-indexed model of the write/read pass schedule.
module tb_ip_2port_ram;
  import ip_2port_ram_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic sys_clk;
  logic sys_rst_n;

  int n_checks;
  int n_pass;

  logic [DATA_W-1:0] mem_model [DEPTH];
  int                cyc;
  state_t            exp_state;
  logic              exp_wr_en, exp_rd_en, exp_err;
  logic [ADDR_W-1:0] exp_wr_addr, exp_rd_addr;
  logic [DATA_W-1:0] exp_wr_data, exp_rd_data, exp_pass;
  logic [DATA_W-1:0] bad_val;

  ip_2port_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic model_reset();
    cyc         = 0;
    exp_state   = IDLE;
    exp_wr_en   = 1'b0;
    exp_rd_en   = 1'b0;
    exp_wr_addr = '0;
    exp_rd_addr = '0;
    exp_wr_data = '0;
    exp_rd_data = '0;
    exp_pass    = '0;
    exp_err     = 1'b0;
  endtask

  // Cycle n after reset release belongs to pass (n-1)/(2*DEPTH); the first
  // DEPTH cycles of each pass write, the rest read.
  task automatic model_step();
    int t, p, o;
    if (exp_wr_en) mem_model[exp_wr_addr] = exp_wr_data;
    if (exp_rd_en) exp_rd_data = mem_model[exp_rd_addr];
    cyc++;
    t = cyc - 1;
    p = t / (2 * DEPTH);
    o = t % (2 * DEPTH);
    exp_pass  = DATA_W'(p);
    exp_wr_en = (o < DEPTH);
    exp_rd_en = !exp_wr_en;
    exp_state = exp_wr_en ? WRITE : READ;
    if (exp_wr_en) begin
      exp_wr_addr = ADDR_W'(o);
      exp_wr_data = DATA_W'(o + p);
    end else begin
      exp_rd_addr = ADDR_W'(o - DEPTH);
    end
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    @(negedge sys_clk);
    model_step();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    #100;
    n_checks++; if (dut.state !== IDLE) $display("[TB] FAIL rst_state: got %0d want %0d", dut.state, IDLE); else n_pass++;
    n_checks++; if (dut.ram_wr_en !== 1'b0) $display("[TB] FAIL rst_wr_en: got %b want 0", dut.ram_wr_en); else n_pass++;
    n_checks++; if (dut.ram_rd_en !== 1'b0) $display("[TB] FAIL rst_rd_en: got %b want 0", dut.ram_rd_en); else n_pass++;
    n_checks++; if (dut.ram_wr_addr !== 5'd0) $display("[TB] FAIL rst_wr_addr: got %h want 0", dut.ram_wr_addr); else n_pass++;
    n_checks++; if (dut.ram_rd_addr !== 5'd0) $display("[TB] FAIL rst_rd_addr: got %h want 0", dut.ram_rd_addr); else n_pass++;
    n_checks++; if (dut.ram_wr_data !== 8'h00) $display("[TB] FAIL rst_wr_data: got %h want 00", dut.ram_wr_data); else n_pass++;
    n_checks++; if (dut.ram_rd_data !== 8'h00) $display("[TB] FAIL rst_rd_data: got %h want 00", dut.ram_rd_data); else n_pass++;
    n_checks++; if (dut.pass_cnt !== 8'h00) $display("[TB] FAIL rst_pass_cnt: got %h want 00", dut.pass_cnt); else n_pass++;
    n_checks++; if (dut.rd_err !== 1'b0) $display("[TB] FAIL rst_rd_err: got %b want 0", dut.rd_err); else n_pass++;
    #100;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_first_pass();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      next_cycle();
      n_checks++; if (dut.state !== exp_state) $display("[TB] FAIL p0_state cyc %0d: got %0d want %0d", cyc, dut.state, exp_state); else n_pass++;
      n_checks++; if (dut.ram_wr_en !== exp_wr_en) $display("[TB] FAIL p0_wr_en cyc %0d: got %b want %b", cyc, dut.ram_wr_en, exp_wr_en); else n_pass++;
      n_checks++; if (dut.ram_rd_en !== exp_rd_en) $display("[TB] FAIL p0_rd_en cyc %0d: got %b want %b", cyc, dut.ram_rd_en, exp_rd_en); else n_pass++;
      if (exp_wr_en) begin
        n_checks++; if (dut.ram_wr_addr !== exp_wr_addr) $display("[TB] FAIL p0_wr_addr cyc %0d: got %h want %h", cyc, dut.ram_wr_addr, exp_wr_addr); else n_pass++;
        n_checks++; if (dut.ram_wr_data !== exp_wr_data) $display("[TB] FAIL p0_wr_data cyc %0d: got %h want %h", cyc, dut.ram_wr_data, exp_wr_data); else n_pass++;
      end else begin
        n_checks++; if (dut.ram_rd_addr !== exp_rd_addr) $display("[TB] FAIL p0_rd_addr cyc %0d: got %h want %h", cyc, dut.ram_rd_addr, exp_rd_addr); else n_pass++;
      end
      n_checks++; if (dut.ram_rd_data !== exp_rd_data) $display("[TB] FAIL p0_rd_data cyc %0d: got %h want %h", cyc, dut.ram_rd_data, exp_rd_data); else n_pass++;
      n_checks++; if (dut.pass_cnt !== exp_pass) $display("[TB] FAIL p0_pass_cnt cyc %0d: got %h want %h", cyc, dut.pass_cnt, exp_pass); else n_pass++;
      n_checks++; if (dut.rd_err !== 1'b0) $display("[TB] FAIL p0_rd_err cyc %0d: got %b want 0", cyc, dut.rd_err); else n_pass++;
    end
  endtask

  task automatic test_second_pass();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      next_cycle();
      n_checks++; if (dut.pass_cnt !== exp_pass) $display("[TB] FAIL p1_pass_cnt cyc %0d: got %h want %h", cyc, dut.pass_cnt, exp_pass); else n_pass++;
      if (exp_wr_en) begin
        n_checks++; if (dut.ram_wr_data !== exp_wr_data) $display("[TB] FAIL p1_wr_data cyc %0d: got %h want %h", cyc, dut.ram_wr_data, exp_wr_data); else n_pass++;
      end else begin
        n_checks++; if (dut.ram_rd_addr !== exp_rd_addr) $display("[TB] FAIL p1_rd_addr cyc %0d: got %h want %h", cyc, dut.ram_rd_addr, exp_rd_addr); else n_pass++;
      end
      n_checks++; if (dut.ram_rd_data !== exp_rd_data) $display("[TB] FAIL p1_rd_data cyc %0d: got %h want %h", cyc, dut.ram_rd_data, exp_rd_data); else n_pass++;
      n_checks++; if (dut.rd_err !== 1'b0) $display("[TB] FAIL p1_rd_err cyc %0d: got %b want 0", cyc, dut.rd_err); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256 * 2 * DEPTH; i++) begin
      next_cycle();
      n_checks++; if (dut.pass_cnt !== exp_pass) $display("[TB] FAIL wrap_pass_cnt cyc %0d: got %h want %h", cyc, dut.pass_cnt, exp_pass); else n_pass++;
      n_checks++; if ((dut.ram_wr_en && dut.ram_rd_en) !== 1'b0) $display("[TB] FAIL wrap_excl cyc %0d: got wr %b rd %b", cyc, dut.ram_wr_en, dut.ram_rd_en); else n_pass++;
      if (exp_wr_en) begin
        n_checks++; if (dut.ram_wr_data !== exp_wr_data) $display("[TB] FAIL wrap_wr_data cyc %0d: got %h want %h", cyc, dut.ram_wr_data, exp_wr_data); else n_pass++;
      end
      n_checks++; if (dut.ram_rd_data !== exp_rd_data) $display("[TB] FAIL wrap_rd_data cyc %0d: got %h want %h", cyc, dut.ram_rd_data, exp_rd_data); else n_pass++;
      n_checks++; if (dut.rd_err !== 1'b0) $display("[TB] FAIL wrap_rd_err cyc %0d: got %b want 0", cyc, dut.rd_err); else n_pass++;
      if (exp_pass == 8'hFF && exp_wr_en && exp_wr_addr == 5'd1) begin
        n_checks++; if (dut.ram_wr_data !== 8'h00) $display("[TB] FAIL wrap_ff_addr1: got %h want 00", dut.ram_wr_data); else n_pass++;
      end
      if (cyc - 1 == 256 * 2 * DEPTH) begin
        n_checks++; if (dut.pass_cnt !== 8'h00) $display("[TB] FAIL wrap_pass_zero: got %h want 00", dut.pass_cnt); else n_pass++;
      end
    end
  endtask

  task automatic test_error_injection();
    int target;
    bit found;
    target = $urandom_range(0, DEPTH - 4);
    found  = 1'b0;
    for (int i = 0; i < 3 * DEPTH && !found; i++) begin
      next_cycle();
      n_checks++; if (dut.rd_err !== 1'b0) $display("[TB] FAIL inj_pre_err cyc %0d: got %b want 0", cyc, dut.rd_err); else n_pass++;
      if (exp_rd_en && exp_rd_addr == ADDR_W'(target)) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      $display("[TB] FAIL inj_find: got no read of addr %0d want one within %0d cycles", target, 3 * DEPTH);
      return;
    end
    n_pass++;
    next_cycle();
    n_checks++; if (dut.ram_rd_data !== exp_rd_data) $display("[TB] FAIL inj_rd_data: got %h want %h", dut.ram_rd_data, exp_rd_data); else n_pass++;
    bad_val = exp_rd_data ^ 8'h5A;
    force dut.ram_rd_data = bad_val;
    n_checks++; if (dut.rd_err !== 1'b0) $display("[TB] FAIL inj_err_early: got %b want 0", dut.rd_err); else n_pass++;
    next_cycle();
    exp_err = 1'b1;
    release dut.ram_rd_data;
    n_checks++; if (dut.rd_err !== exp_err) $display("[TB] FAIL inj_err_rise: got %b want %b", dut.rd_err, exp_err); else n_pass++;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      next_cycle();
      n_checks++; if (dut.rd_err !== exp_err) $display("[TB] FAIL inj_err_sticky cyc %0d: got %b want %b", cyc, dut.rd_err, exp_err); else n_pass++;
      n_checks++; if (dut.ram_rd_data !== exp_rd_data) $display("[TB] FAIL inj_rd_data_after cyc %0d: got %h want %h", cyc, dut.ram_rd_data, exp_rd_data); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_read();
    int r, hold;
    bit found;
    r     = $urandom_range(1, DEPTH - 2);
    hold  = $urandom_range(1, 4);
    found = 1'b0;
    for (int i = 0; i < 3 * DEPTH && !found; i++) begin
      next_cycle();
      if (exp_rd_en && exp_rd_addr == ADDR_W'(r)) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      $display("[TB] FAIL mid_find: got no read of addr %0d want one within %0d cycles", r, 3 * DEPTH);
      return;
    end
    n_pass++;
    #3;
    sys_rst_n = 1'b0;
    #1;
    n_checks++; if (dut.state !== IDLE) $display("[TB] FAIL mid_state: got %0d want %0d", dut.state, IDLE); else n_pass++;
    n_checks++; if (dut.ram_wr_en !== 1'b0) $display("[TB] FAIL mid_wr_en: got %b want 0", dut.ram_wr_en); else n_pass++;
    n_checks++; if (dut.ram_rd_en !== 1'b0) $display("[TB] FAIL mid_rd_en: got %b want 0", dut.ram_rd_en); else n_pass++;
    n_checks++; if (dut.ram_rd_addr !== 5'd0) $display("[TB] FAIL mid_rd_addr: got %h want 0", dut.ram_rd_addr); else n_pass++;
    n_checks++; if (dut.ram_wr_addr !== 5'd0) $display("[TB] FAIL mid_wr_addr: got %h want 0", dut.ram_wr_addr); else n_pass++;
    n_checks++; if (dut.ram_wr_data !== 8'h00) $display("[TB] FAIL mid_wr_data: got %h want 00", dut.ram_wr_data); else n_pass++;
    n_checks++; if (dut.ram_rd_data !== 8'h00) $display("[TB] FAIL mid_rd_data: got %h want 00", dut.ram_rd_data); else n_pass++;
    n_checks++; if (dut.pass_cnt !== 8'h00) $display("[TB] FAIL mid_pass_cnt: got %h want 00", dut.pass_cnt); else n_pass++;
    n_checks++; if (dut.rd_err !== 1'b0) $display("[TB] FAIL mid_rd_err: got %b want 0", dut.rd_err); else n_pass++;
    repeat (hold) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4 * DEPTH; i++) begin
      next_cycle();
      n_checks++; if (dut.state !== exp_state) $display("[TB] FAIL post_state cyc %0d: got %0d want %0d", cyc, dut.state, exp_state); else n_pass++;
      n_checks++; if (dut.ram_wr_en !== exp_wr_en) $display("[TB] FAIL post_wr_en cyc %0d: got %b want %b", cyc, dut.ram_wr_en, exp_wr_en); else n_pass++;
      if (exp_wr_en) begin
        n_checks++; if (dut.ram_wr_addr !== exp_wr_addr) $display("[TB] FAIL post_wr_addr cyc %0d: got %h want %h", cyc, dut.ram_wr_addr, exp_wr_addr); else n_pass++;
        n_checks++; if (dut.ram_wr_data !== exp_wr_data) $display("[TB] FAIL post_wr_data cyc %0d: got %h want %h", cyc, dut.ram_wr_data, exp_wr_data); else n_pass++;
      end else begin
        n_checks++; if (dut.ram_rd_addr !== exp_rd_addr) $display("[TB] FAIL post_rd_addr cyc %0d: got %h want %h", cyc, dut.ram_rd_addr, exp_rd_addr); else n_pass++;
      end
      n_checks++; if (dut.ram_rd_data !== exp_rd_data) $display("[TB] FAIL post_rd_data cyc %0d: got %h want %h", cyc, dut.ram_rd_data, exp_rd_data); else n_pass++;
      n_checks++; if (dut.pass_cnt !== exp_pass) $display("[TB] FAIL post_pass_cnt cyc %0d: got %h want %h", cyc, dut.pass_cnt, exp_pass); else n_pass++;
      n_checks++; if (dut.rd_err !== 1'b0) $display("[TB] FAIL post_rd_err cyc %0d: got %b want 0", cyc, dut.rd_err); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    $display("[TB] starting ip_2port_ram self-test bench");
    test_reset();
    test_first_pass();
    test_second_pass();
    test_wrap();
    test_error_injection();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
